// File: rtl/booth_pkg.sv
// booth_pkg: FSM state, Booth digit encoding and geometry helpers shared by the
// sequential Booth multiplier and its digit recoder.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [1:0] {ZERO, PM1, PM2} digit_mag_e;

  typedef struct packed {
    digit_mag_e mag;
    logic       neg;
  } digit_t;

  function automatic int booth_steps(input int width, input int radix);
    return (radix == 4) ? width / 2 : width;
  endfunction

  // Accumulator width: one guard bit for radix 2, two for the +/-2M addend of radix 4.
  function automatic int booth_aw(input int width, input int radix);
    return (radix == 4) ? width + 2 : width + 1;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps a Booth digit window {Q[1],Q[0],q_1} to addend magnitude
// and negate flag. Radix 2 looks only at {Q[0],q_1}.
module booth_recoder
  import booth_pkg::*;
#(
  parameter int RADIX = 2
) (
  input  logic [2:0] win,
  output digit_t     dig
);

  always_comb begin
    dig = '{mag: ZERO, neg: 1'b0};
    if (RADIX == 4) begin
      case (win)
        3'b001, 3'b010: dig = '{mag: PM1, neg: 1'b0};
        3'b011:         dig = '{mag: PM2, neg: 1'b0};
        3'b100:         dig = '{mag: PM2, neg: 1'b1};
        3'b101, 3'b110: dig = '{mag: PM1, neg: 1'b1};
        default:        dig = '{mag: ZERO, neg: 1'b0};
      endcase
    end else begin
      case (win[1:0])
        2'b01:   dig = '{mag: PM1, neg: 1'b0};
        2'b10:   dig = '{mag: PM1, neg: 1'b1};
        default: dig = '{mag: ZERO, neg: 1'b0};
      endcase
    end
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: iterative signed Booth multiplier, one digit per clock.
// Optional early termination when the unconsumed multiplier bits are uniform: BOOTH_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | retiring one Booth digit per cycle, busy high
// DONE  | product held on out_p, out_valid high until out_ready
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADIX = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int STEPS = booth_steps(WIDTH, RADIX);
  localparam int AW    = booth_aw(WIDTH, RADIX);
  localparam int SH    = (RADIX == 4) ? 2 : 1;
  localparam int FW    = AW + WIDTH + 1;
  localparam int CW    = $clog2(STEPS);

  if (RADIX != 2 && RADIX != 4) begin : g_bad_radix
    $error("booth_seq_multiplier: RADIX must be 2 or 4");
  end
  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("booth_seq_multiplier: WIDTH must be even and >= 4");
  end

  state_e               state_q, state_d;
  logic [AW-1:0]        a_q, a_d, m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  digit_t               dig;
  logic [AW-1:0]        addend, sum;
  logic [FW-1:0]        full, shifted;
  logic                 early;
  int                   sh_amt;

  booth_recoder #(.RADIX(RADIX)) u_recoder (
    .win ({q_q[1], q_q[0], q1_q}),
    .dig (dig)
  );

`ifdef BOOTH_EARLY_TERM_EN
  // Bits still unconsumed after this cycle's digit, including the one that becomes q_1.
  logic [WIDTH-1:0] rem_mask, rem_bits;
  always_comb begin
    rem_mask = (WIDTH'(1) << (int'(cnt_q) * SH + 1)) - WIDTH'(1);
    rem_bits = q_q >> (SH - 1);
    early    = ((rem_bits & rem_mask) == '0) || ((rem_bits & rem_mask) == rem_mask);
  end
`else
  assign early = 1'b0;
`endif

  always_comb begin
    case (dig.mag)
      PM1:     addend = m_q;
      PM2:     addend = m_q << 1;
      default: addend = '0;
    endcase
    sum     = dig.neg ? (a_q + ~addend + AW'(1)) : (a_q + addend);
    full    = {sum, q_q, q1_q};
    sh_amt  = early ? (int'(cnt_q) + 1) * SH : SH;
    shifted = $signed(full) >>> sh_amt;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_d     = AW'($signed(in_a));
          a_d     = '0;
          q_d     = in_b;
          q1_d    = 1'b0;
          cnt_d   = CW'(STEPS - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        a_d  = shifted[FW-1 -: AW];
        q_d  = shifted[WIDTH:1];
        q1_d = shifted[0];
        if (cnt_q == '0 || early) begin
          p_d     = shifted[2*WIDTH:1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign out_p = p_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier across WIDTH/RADIX variants;
// latency expectations follow BOOTH_EARLY_TERM_EN when it is defined.
module tb_booth_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_a, in_b;
  logic [4:0]  iv, ordy, ir, ov, bz;
  logic [63:0] p0, p1;
  logic [7:0]  p2, p3;
  logic [15:0] p4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier #(.WIDTH(32), .RADIX(2)) u_w32r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_p(p0), .busy(bz[0]));
  booth_seq_multiplier #(.WIDTH(32), .RADIX(4)) u_w32r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_p(p1), .busy(bz[1]));
  booth_seq_multiplier #(.WIDTH(4), .RADIX(2)) u_w4r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(in_a[3:0]), .in_b(in_b[3:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_p(p2), .busy(bz[2]));
  booth_seq_multiplier #(.WIDTH(4), .RADIX(4)) u_w4r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_a(in_a[3:0]), .in_b(in_b[3:0]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_p(p3), .busy(bz[3]));
  booth_seq_multiplier #(.WIDTH(8), .RADIX(4)) u_w8r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .out_valid(ov[4]), .out_ready(ordy[4]), .out_p(p4), .busy(bz[4]));

  function automatic logic [63:0] get_p(input int k);
    case (k)
      0:       return p0;
      1:       return p1;
      2:       return {{56{p2[7]}}, p2};
      3:       return {{56{p3[7]}}, p3};
      default: return {{48{p4[15]}}, p4};
    endcase
  endfunction

  function automatic int width_of(input int k);
    case (k)
      0, 1:    return 32;
      2, 3:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input int w);
    logic signed [63:0] sa, sb;
    sa = $signed({a << (32 - w), 32'h0}) >>> (64 - w);
    sb = $signed({b << (32 - w), 32'h0}) >>> (64 - w);
    return sa * sb;
  endfunction

  // One full transaction with out_ready high; lat counts the accepting edge as cycle 1.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int lat);
    in_a = a;
    in_b = b;
    ordy[k] = 1'b1;
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = 1;
    while (!ov[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    p = get_p(k);
    if (lat >= 200) begin
      tests++;
      fails++;
      $display("FAIL op_timeout dut%0d: out_valid not seen after %0d cycles, required within 200", k, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = '0;
    ordy = '0;
    in_a = '0;
    in_b = '0;
    #12;
    tests++; if (ir !== 5'b11111) begin fails++; $display("FAIL reset_in_ready: got %b required 11111", ir); end
    tests++; if (ov !== 5'b00000) begin fails++; $display("FAIL reset_out_valid: got %b required 00000", ov); end
    tests++; if (bz !== 5'b00000) begin fails++; $display("FAIL reset_busy: got %b required 00000", bz); end
    tests++; if ({p0, p1} !== 128'h0) begin fails++; $display("FAIL reset_out_p: got %h %h required 0", p0, p1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_radix2_directed();
    logic [63:0] p;
    int lat, exp_lat;
`ifdef BOOTH_EARLY_TERM_EN
    exp_lat = 4;
`else
    exp_lat = 33;
`endif
    run_op(0, 32'hFFFF_FFF9, 32'h0000_0003, p, lat);
    tests++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin fails++; $display("FAIL r2_neg7x3: got %h required ffffffffffffffeb", p); end
    tests++; if (lat != exp_lat) begin fails++; $display("FAIL r2_latency: got %0d required %0d", lat, exp_lat); end
    run_op(0, 32'h8000_0000, 32'h8000_0000, p, lat);
    tests++; if (p !== 64'h4000_0000_0000_0000) begin fails++; $display("FAIL r2_minxmin: got %h required 4000000000000000", p); end
    run_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, p, lat);
    tests++; if (p !== 64'h3FFF_FFFF_0000_0001) begin fails++; $display("FAIL r2_maxxmax: got %h required 3fffffff00000001", p); end
  endtask

  task automatic test_radix4_directed();
    logic [63:0] p;
    int lat;
    run_op(1, 32'h8000_0000, 32'h8000_0000, p, lat);
    tests++; if (p !== 64'h4000_0000_0000_0000) begin fails++; $display("FAIL r4_minxmin: got %h required 4000000000000000", p); end
    tests++; if (lat != 17) begin fails++; $display("FAIL r4_latency: got %0d required 17", lat); end
    run_op(1, 32'h7FFF_FFFF, 32'h8000_0000, p, lat);
    tests++; if (p !== 64'hC000_0000_8000_0000) begin fails++; $display("FAIL r4_maxxmin: got %h required c000000080000000", p); end
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat);
    tests++; if (p !== 64'h1) begin fails++; $display("FAIL r4_m1xm1: got %h required 1", p); end
    run_op(1, 32'h0000_3039, 32'hFFFF_FFFE, p, lat);
    tests++; if (p !== 64'hFFFF_FFFF_FFFF_9F8E) begin fails++; $display("FAIL r4_12345xm2: got %h required ffffffffffff9f8e", p); end
    run_op(4, 32'h0000_0080, 32'h0000_0080, p, lat);
    tests++; if (p[15:0] !== 16'h4000) begin fails++; $display("FAIL w8r4_minxmin: got %h required 4000", p[15:0]); end
    run_op(4, 32'h0000_007F, 32'h0000_0080, p, lat);
    tests++; if (p[15:0] !== 16'hC080) begin fails++; $display("FAIL w8r4_maxxmin: got %h required c080", p[15:0]); end
  endtask

  task automatic test_back_pressure();
    logic [63:0] hold;
    int cyc;
    bit ok;
    in_a = 32'h0000_0005;
    in_b = 32'hFFFF_FFFD;
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    tests++; if (ir[0] !== 1'b0 || bz[0] !== 1'b1) begin fails++; $display("FAIL run_flags: in_ready=%b busy=%b required 0 1", ir[0], bz[0]); end
    cyc = 0;
    while (!ov[0] && cyc < 100) begin @(posedge clk); #1; cyc++; end
    tests++; if (ov[0] !== 1'b1) begin fails++; $display("FAIL bp_valid_timeout: out_valid=%b after %0d cycles, required 1", ov[0], cyc); end
    hold = p0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = 32'h0000_0063;
      in_b = 32'h0000_0063;
      iv[0] = (i % 2 == 0);
      @(posedge clk); #1;
      if (p0 !== hold || ov[0] !== 1'b1 || ir[0] !== 1'b0) ok = 1'b0;
    end
    iv[0] = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL bp_hold: out_p/out_valid/in_ready changed under back-pressure, final p=%h required %h", p0, hold); end
    tests++; if (hold !== 64'hFFFF_FFFF_FFFF_FFF1) begin fails++; $display("FAIL bp_product: got %h required fffffffffffffff1", hold); end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    tests++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
      fails++; $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0 1 0", ov[0], ir[0], bz[0]);
    end
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0 || bz[0] !== 1'b0) ok = 1'b0;
    end
    tests++; if (!ok) begin fails++; $display("FAIL bp_ignored_pulses: out_valid=%b busy=%b required idle", ov[0], bz[0]); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] first;
    int n;
    in_a = 32'h0000_0003;
    in_b = 32'h0000_0004;
    ordy[1] = 1'b1;
    iv[1] = 1'b1;
    @(posedge clk); #1;
    in_a = 32'hFFFF_FFFE;
    in_b = 32'h0000_0006;
    n = 0;
    while (!ov[1] && n < 100) begin @(posedge clk); #1; n++; end
    first = p1;
    tests++; if (first !== 64'd12) begin fails++; $display("FAIL b2b_first: got %h required c", first); end
    @(posedge clk); #1;
    n = 1;
    tests++; if (ir[1] !== 1'b1 || ov[1] !== 1'b0) begin fails++; $display("FAIL b2b_idle: in_ready=%b out_valid=%b required 1 0", ir[1], ov[1]); end
    @(posedge clk); #1;
    n = 2;
    iv[1] = 1'b0;
    while (!ov[1] && n < 100) begin @(posedge clk); #1; n++; end
    tests++; if (p1 !== 64'hFFFF_FFFF_FFFF_FFF4) begin fails++; $display("FAIL b2b_second: got %h required fffffffffffffff4", p1); end
`ifndef BOOTH_EARLY_TERM_EN
    tests++; if (n != 18) begin fails++; $display("FAIL b2b_period: got %0d cycles required 18", n); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] p;
    int lat;
    bit stale;
    in_a = 32'h0000_0009;
    in_b = 32'h5555_5555;
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0 || p0 !== 64'h0) begin
      fails++; $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b p=%h required 1 0 0 0", ir[0], ov[0], bz[0], p0);
    end
    #2;
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0) stale = 1'b1;
    end
    tests++; if (stale) begin fails++; $display("FAIL midrun_stale: out_valid seen after aborted op, required none"); end
    run_op(0, 32'h0000_0002, 32'h0000_0003, p, lat);
    tests++; if (p !== 64'd6) begin fails++; $display("FAIL midrun_next: got %h required 6", p); end
  endtask

  task automatic test_latency_edges();
    logic [63:0] p;
    int lat, exp_lat;
    for (int k = 0; k < 2; k++) begin
`ifdef BOOTH_EARLY_TERM_EN
      exp_lat = 2;
`else
      exp_lat = (k == 0) ? 33 : 17;
`endif
      run_op(k, 32'h1234_5678, 32'h0000_0000, p, lat);
      tests++; if (p !== 64'h0) begin fails++; $display("FAIL edge_b0_dut%0d: got %h required 0", k, p); end
      tests++; if (lat != exp_lat) begin fails++; $display("FAIL edge_b0_lat_dut%0d: got %0d required %0d", k, lat, exp_lat); end
      run_op(k, 32'h0000_3039, 32'hFFFF_FFFF, p, lat);
      tests++; if (p !== 64'hFFFF_FFFF_FFFF_CFC7) begin fails++; $display("FAIL edge_bm1_dut%0d: got %h required ffffffffffffcfc7", k, p); end
      tests++; if (lat != exp_lat) begin fails++; $display("FAIL edge_bm1_lat_dut%0d: got %0d required %0d", k, lat, exp_lat); end
      run_op(k, 32'h8000_0000, 32'h0000_0001, p, lat);
      tests++; if (p !== 64'hFFFF_FFFF_8000_0000) begin fails++; $display("FAIL edge_b1_dut%0d: got %h required ffffffff80000000", k, p); end
    end
  endtask

  task automatic test_sweep();
    logic [63:0] p, e;
    logic [31:0] a, b;
    int lat, nbad;
    for (int k = 2; k < 4; k++) begin
      nbad = 0;
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          a = 32'(i);
          b = 32'(j);
          run_op(k, a, b, p, lat);
          e = ref_prod(a, b, 4);
          tests++;
          if (p !== e) begin
            fails++;
            if (nbad < 8) $display("FAIL sweep_w4_dut%0d a=%0d b=%0d: got %h required %h", k, i, j, p, e);
            nbad++;
          end
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2 || k == 3) continue;
      nbad = 0;
      for (int n = 0; n < 120; n++) begin
        a = $urandom;
        b = $urandom;
        run_op(k, a, b, p, lat);
        e = ref_prod(a, b, width_of(k));
        if (width_of(k) == 8) e = {{48{e[15]}}, e[15:0]};
        tests++;
        if (p !== e) begin
          fails++;
          if (nbad < 8) $display("FAIL sweep_rand_dut%0d a=%h b=%h: got %h required %h", k, a, b, p, e);
          nbad++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_radix2_directed();
    test_radix4_directed();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_run();
    test_latency_edges();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
